// File: rtl/psa_search_ctrl.sv
// Pattern search sequencer: walks a BRAM block one byte per READ/CMP pair (2 cycles/byte) and reports the first match.
// No backpressure: start/resume are accepted only when idle, and pattern writes are dropped while busy.
module psa_search_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MAX_PAT = 16
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic                         pat_wr_en,
  input  logic [$clog2(MAX_PAT)-1:0]   pat_wr_idx,
  input  logic [DATA_W-1:0]            pat_wr_data,
  input  logic [$clog2(MAX_PAT+1)-1:0] pat_len,
  input  logic [ADDR_W-1:0]            blk_base,
  input  logic [ADDR_W:0]              blk_len,
  input  logic                         start,
  input  logic                         resume,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic                         err,
  output logic [ADDR_W-1:0]            match_addr,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_dout
);

  localparam int IDX_W = $clog2(MAX_PAT);
  localparam int PL_W  = $clog2(MAX_PAT + 1);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] pat [MAX_PAT];
  logic [LEN_W-1:0]  cand;
  logic [PL_W-1:0]   j;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [PL_W-1:0]   plen_q;

  logic              start_bad;
  logic [LEN_W-1:0]  last_cand;
  logic [LEN_W-1:0]  cand_inc;
  logic              last_byte;
  logic              byte_eq;

  assign start_bad = (pat_len == '0) || (pat_len > PL_W'(MAX_PAT)) ||
                     (LEN_W'(pat_len) > blk_len);
  // Legal starts guarantee plen_q <= len_q, so this never underflows.
  assign last_cand = len_q - LEN_W'(plen_q);
  assign cand_inc  = cand + LEN_W'(1);
  assign last_byte = (j == plen_q - PL_W'(1));
  assign byte_eq   = (mem_dout == pat[j[IDX_W-1:0]]);

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] b,
                                                input logic [LEN_W-1:0]  c,
                                                input logic [PL_W-1:0]   jj);
    logic [LEN_W-1:0] off;
    off = c + LEN_W'(jj);
    return b + off[ADDR_W-1:0];
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < MAX_PAT; i++) pat[i] <= '0;
    end else if (pat_wr_en && !busy) begin
      pat[pat_wr_idx] <= pat_wr_data;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      err        <= 1'b0;
      match_addr <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      cand       <= '0;
      j          <= '0;
      base_q     <= '0;
      len_q      <= '0;
      plen_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base_q <= blk_base;
            len_q  <= blk_len;
            plen_q <= pat_len;
            cand   <= '0;
            j      <= '0;
            found  <= 1'b0;
            if (start_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
              mem_en   <= 1'b1;
              mem_addr <= blk_base;
            end
          end else if (state == DONE && resume && found) begin
            found <= 1'b0;
            cand  <= cand_inc;
            j     <= '0;
            // Out of candidates: done is re-asserted in the same edge.
            if (cand_inc > last_cand) begin
              done <= 1'b1;
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              done     <= 1'b0;
              mem_en   <= 1'b1;
              mem_addr <= rd_addr(base_q, cand_inc, '0);
            end
          end
        end

        READ: begin
          mem_en <= 1'b0;
          state  <= CMP;
        end

        CMP: begin
          if (byte_eq && last_byte) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            found      <= 1'b1;
            match_addr <= base_q + cand[ADDR_W-1:0];
          end else if (byte_eq) begin
            j        <= j + PL_W'(1);
            state    <= READ;
            mem_en   <= 1'b1;
            mem_addr <= rd_addr(base_q, cand, j + PL_W'(1));
          end else begin
            j    <= '0;
            cand <= cand_inc;
            if (cand_inc > last_cand) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              found <= 1'b0;
            end else begin
              state    <= READ;
              mem_en   <= 1'b1;
              mem_addr <= rd_addr(base_q, cand_inc, '0);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psa_search_ctrl.sv
// Directed bench for psa_search_ctrl with a BRAM model and a queue of expected search results.
module tb_psa_search_ctrl;

  logic       CLK100MHZ = 1'b0;
  logic       reset;
  logic       pat_wr_en;
  logic [3:0] pat_wr_idx;
  logic [7:0] pat_wr_data;
  logic [4:0] pat_len;
  logic [7:0] blk_base;
  logic [8:0] blk_len;
  logic       start, resume;
  logic       busy, done, found, err;
  logic [7:0] match_addr;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_dout;

  always #5 CLK100MHZ = ~CLK100MHZ;

  psa_search_ctrl dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset),
    .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx), .pat_wr_data(pat_wr_data),
    .pat_len(pat_len), .blk_base(blk_base), .blk_len(blk_len),
    .start(start), .resume(resume),
    .busy(busy), .done(done), .found(found), .err(err), .match_addr(match_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  typedef struct {
    logic       found;
    logic       err;
    logic [7:0] addr;
    int         cyc;
  } exp_t;

  logic [7:0] mem   [256];
  logic [7:0] m_pat [16];
  exp_t       sbq[$];
  int         exp_rd[$];
  int         rd_log[$];
  int         m_base, m_len, m_plen, m_cand;
  logic       m_found;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  // One-cycle-latency read port.
  always @(posedge CLK100MHZ) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
    cyc++;
  endtask

  task automatic write_pat(input int idx, input int data);
    pat_wr_en   = 1'b1;
    pat_wr_idx  = 4'(idx);
    pat_wr_data = 8'(data);
    tick();
    pat_wr_en   = 1'b0;
    m_pat[idx]  = 8'(data);
  endtask

  // Reference search from candidate c0: one entry on sbq, expected reads on exp_rd.
  task automatic model_run(input int c0);
    int c, jj, bytes, a;
    logic f;
    c = c0; bytes = 0; f = 1'b0;
    while (!f && c <= m_len - m_plen) begin
      jj = 0;
      while (jj < m_plen) begin
        a = (m_base + c + jj) % 256;
        exp_rd.push_back(a);
        bytes++;
        if (mem[a] != m_pat[jj]) break;
        jj++;
      end
      if (jj == m_plen) f = 1'b1;
      else c++;
    end
    m_cand  = c;
    m_found = f;
    sbq.push_back('{f, 1'b0, 8'((m_base + c) % 256), 2 * bytes + 1});
  endtask

  task automatic do_start(input int base, input int len, input int plen);
    blk_base = 8'(base);
    blk_len  = 9'(len);
    pat_len  = 5'(plen);
    m_base = base; m_len = len; m_plen = plen;
    rd_log.delete();
    exp_rd.delete();
    if (plen == 0 || plen > 16 || plen > len) begin
      m_found = 1'b0;
      sbq.push_back('{1'b0, 1'b1, 8'd0, 1});
    end else begin
      model_run(0);
    end
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic do_resume();
    rd_log.delete();
    exp_rd.delete();
    if (m_found) model_run(m_cand + 1);
    resume = 1'b1;
    cyc    = 0;
    tick();
    resume = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n;
    while (done !== 1'b1 && cyc < 300) tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pending"}, sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_cycles"}, cyc, e.cyc);
      chk({tag, "_found"}, found, e.found);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_busy"}, busy, 0);
      if (e.found) chk({tag, "_match_addr"}, match_addr, e.addr);
    end
    chk({tag, "_nreads"}, rd_log.size(), exp_rd.size());
    n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < n; i++) chk({tag, "_rdaddr"}, rd_log[i], exp_rd[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    for (int i = 0; i < 16; i++) m_pat[i] = 8'h00;
    mem[10] = 8'h41; mem[11] = 8'h43; mem[12] = 8'h41;
    mem[13] = 8'h42; mem[14] = 8'h00; mem[15] = 8'h41;
    mem[254] = 8'h01; mem[255] = 8'h02; mem[0] = 8'h03; mem[1] = 8'h04;
    mem[40] = 8'hAA; mem[41] = 8'hBB;
    for (int i = 0; i < 16; i++) mem[100 + i] = 8'(8'h10 + i);
    m_found = 1'b0; m_cand = 0;

    reset = 1'b1; pat_wr_en = 1'b0; pat_wr_idx = '0; pat_wr_data = '0;
    pat_len = '0; blk_base = '0; blk_len = '0; start = 1'b0; resume = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_match_addr", match_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    // Basic match, then resume to exhaustion, then an ignored resume.
    write_pat(0, 8'h41);
    write_pat(1, 8'h42);
    do_start(10, 6, 2);
    chk("s1_busy_after_start", busy, 1);
    chk("s1_done_after_start", done, 0);
    wait_done("s1");
    do_resume();
    wait_done("s2");
    do_resume();
    tick(); tick(); tick();
    chk("s2_ignored_done", done, 1);
    chk("s2_ignored_found", found, 0);
    chk("s2_ignored_busy", busy, 0);
    chk("s2_ignored_reads", rd_log.size(), 0);

    // Illegal length.
    do_start(20, 3, 5);
    wait_done("s3");

    // Address wrap past 255.
    write_pat(0, 8'h03);
    write_pat(1, 8'h04);
    do_start(254, 4, 2);
    wait_done("s4");

    // Reset during CMP clears the pattern buffer and all outputs.
    write_pat(0, 8'hAA);
    write_pat(1, 8'hBB);
    do_start(40, 4, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_found", found, 0);
    chk("s5_rst_err", err, 0);
    chk("s5_rst_mem_en", mem_en, 0);
    chk("s5_rst_mem_addr", mem_addr, 0);
    chk("s5_rst_match_addr", match_addr, 0);
    sbq.delete();
    for (int i = 0; i < 16; i++) m_pat[i] = 8'h00;
    m_found = 1'b0;
    do_start(40, 4, 2);
    wait_done("s5_cleared");

    // Pattern write and start while busy must not disturb anything.
    write_pat(0, 8'hAA);
    write_pat(1, 8'hBB);
    do_start(40, 4, 2);
    pat_wr_en = 1'b1; pat_wr_idx = 4'd0; pat_wr_data = 8'h00;
    start = 1'b1; blk_base = 8'd0; pat_len = 5'd1;
    tick();
    pat_wr_en = 1'b0; start = 1'b0;
    wait_done("s5_busy");
    do_start(40, 4, 2);
    wait_done("s5_buf_kept");

    // start wins over resume when both arrive in DONE with found=1.
    resume = 1'b1;
    do_start(40, 4, 2);
    resume = 1'b0;
    wait_done("prio");

    // Full-length pattern, then resume with no candidates left.
    for (int i = 0; i < 16; i++) write_pat(i, 8'h10 + i);
    do_start(100, 16, 16);
    wait_done("s6");
    do_resume();
    wait_done("s6_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
